// File: rtl/axis_frame_reader_if.sv
// Byte-wide AXI-Stream link between a stream FIFO and the frame reader.
interface axis_frame_reader_if;
    logic [7:0] tdata;
    logic       tvalid;
    logic       tready;
    logic       tlast;
    logic       tuser;

    modport master (
        output tdata,
        output tvalid,
        output tlast,
        output tuser,
        input  tready
    );

    modport slave (
        input  tdata,
        input  tvalid,
        input  tlast,
        input  tuser,
        output tready
    );
endinterface

// File: rtl/axis_frame_reader.sv
// Receive-side frame buffer: stores one AXI-Stream frame, publishes it after a
// good tlast, drops bad or oversize frames, and exposes a registered read port.
module axis_frame_reader #(
    parameter int MAX_FRAME_BYTES = 256,
    parameter int ADDR_WIDTH      = $clog2(MAX_FRAME_BYTES)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    axis_frame_reader_if.slave    s_axis,
    output logic                  frame_valid,
    output logic [ADDR_WIDTH:0]   frame_length,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    input  logic                  frame_release,
    output logic [15:0]           drop_count
);

    typedef enum logic [1:0] {
        RECEIVE = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(MAX_FRAME_BYTES - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
    logic [ADDR_WIDTH:0]   frameLength_q, frameLength_d;
    logic [15:0]           dropCount_q, dropCount_d;
    logic [7:0]            rdData_q;
    logic [7:0]            mem [MAX_FRAME_BYTES];

    logic readyInt;
    logic beatAccepted;
    logic memWrite;
    logic dropFrame;

    // State register; reset drops any partial frame without counting it
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RECEIVE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision from the accepted beat and the release pulse
    always_comb begin
        state_d = state_q;
        case (state_q)
            RECEIVE: begin
                if (beatAccepted) begin
                    if (s_axis.tlast) begin
                        state_d = s_axis.tuser ? RECEIVE : HOLD;
                    end else if (wrPtr_q == LAST_ADDR) begin
                        state_d = DISCARD;
                    end
                end
            end
            DISCARD: begin
                if (beatAccepted && s_axis.tlast) begin
                    state_d = RECEIVE;
                end
            end
            HOLD: begin
                if (frame_release) begin
                    state_d = RECEIVE;
                end
            end
            default: state_d = RECEIVE;
        endcase
    end

    // Handshake, publish flag and buffer/drop strobes decoded from the state
    always_comb begin
        readyInt      = reset_n && (state_q != HOLD);
        s_axis.tready = readyInt;
        frame_valid   = (state_q == HOLD);
        beatAccepted  = s_axis.tvalid && readyInt;
        memWrite      = beatAccepted && (state_q == RECEIVE);
        dropFrame     = beatAccepted && s_axis.tlast &&
                        (((state_q == RECEIVE) && s_axis.tuser) || (state_q == DISCARD));
    end

    // Next values of write pointer, published length and saturating drop count
    always_comb begin
        wrPtr_d       = wrPtr_q;
        frameLength_d = frameLength_q;
        dropCount_d   = dropCount_q;
        case (state_q)
            RECEIVE: begin
                if (beatAccepted) begin
                    if (s_axis.tlast && s_axis.tuser) begin
                        wrPtr_d = '0;
                    end else begin
                        wrPtr_d = wrPtr_q + ADDR_WIDTH'(1);
                    end
                    if (s_axis.tlast && !s_axis.tuser) begin
                        frameLength_d = {1'b0, wrPtr_q} + (ADDR_WIDTH + 1)'(1);
                    end
                end
            end
            DISCARD: begin
                if (beatAccepted && s_axis.tlast) begin
                    wrPtr_d = '0;
                end
            end
            HOLD: begin
                if (frame_release) begin
                    wrPtr_d = '0;
                end
            end
            default: wrPtr_d = '0;
        endcase
        if (dropFrame && (dropCount_q != 16'hFFFF)) begin
            dropCount_d = dropCount_q + 16'd1;
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wrPtr_q       <= '0;
            frameLength_q <= '0;
            dropCount_q   <= '0;
        end else begin
            wrPtr_q       <= wrPtr_d;
            frameLength_q <= frameLength_d;
            dropCount_q   <= dropCount_d;
        end
    end

    // Frame storage; contents survive reset and are frozen while holding
    always_ff @(posedge clk) begin
        if (memWrite) begin
            mem[wrPtr_q] <= s_axis.tdata;
        end
    end

    // Registered random-access read port, active in every state
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rdData_q <= '0;
        end else begin
            rdData_q <= mem[rd_addr];
        end
    end

    assign frame_length = frameLength_q;
    assign drop_count   = dropCount_q;
    assign rd_data      = rdData_q;

endmodule

// File: doc/axis_frame_reader.md
# axis_frame_reader

Receive-side frame buffer that drains 8-bit AXI-Stream frames from the output of a stream FIFO and holds one complete frame at a time for random-access reading by a register or CPU-facing block. Frames are stored byte by byte in an internal buffer. A frame is published only after a good `tlast`. Frames flagged bad (`tuser` on the last beat) or longer than the buffer are discarded and counted. The block backpressures the stream while a published frame is waiting to be released.

## Interface
- `MAX_FRAME_BYTES`, default 256: buffer capacity in bytes; power of two, at least 2.
- `ADDR_WIDTH`, default `$clog2(MAX_FRAME_BYTES)`: read-address width.
- `clk`  in  1  single clock for all logic.
- `reset_n`  in  1  asynchronous assert, active-low reset.
- `s_axis_tdata`  in  8  stream byte.
- `s_axis_tvalid`  in  1  stream beat valid.
- `s_axis_tready`  out  1  stream beat accepted when high together with `tvalid`.
- `s_axis_tlast`  in  1  last beat of the frame.
- `s_axis_tuser`  in  1  bad-frame marker; sampled only on the `tlast` beat.
- `frame_valid`  out  1  a complete good frame is held and readable.
- `frame_length`  out  ADDR_WIDTH+1  byte count of the held frame, 1..`MAX_FRAME_BYTES`.
- `rd_addr`  in  ADDR_WIDTH  buffer byte address.
- `rd_data`  out  8  registered buffer read data.
- `frame_release`  in  1  single-cycle pulse that frees the held frame.
- `drop_count`  out  16  saturating count of discarded frames.

## Operation
- The FSM has three states: RECEIVE, HOLD and DISCARD. Reset state is RECEIVE.
- A beat is accepted when `s_axis_tvalid && s_axis_tready`.
- `s_axis_tready` = `reset_n && (state != HOLD)`.
- **RECEIVE:** each accepted beat writes `mem[wr_ptr]` and then increments `wr_ptr`.
  - Accepted beat with `tlast=1, tuser=0`: set `frame_length = wr_ptr+1`, go to HOLD.
  - Accepted beat with `tlast=1, tuser=1`: increment `drop_count`, clear `wr_ptr` to 0, stay in RECEIVE.
  - Accepted beat with `tlast=0` when `wr_ptr == MAX_FRAME_BYTES-1` (oversize frame): go to DISCARD.
  - A frame of exactly `MAX_FRAME_BYTES` ending with `tlast` on that beat is good.
- **DISCARD:** accepts every beat without storing it. On the accepted `tlast` beat (`tuser` ignored): increment `drop_count`, clear `wr_ptr` to 0, go to RECEIVE.
- **HOLD:** `frame_valid=1` and buffer contents are frozen. When `frame_release=1`: clear `wr_ptr` to 0, clear `frame_valid`, go to RECEIVE.
- `frame_release` outside HOLD is ignored.
- `rd_data <= mem[rd_addr]` every cycle, in every state.
  - Contents are only defined in HOLD for `rd_addr < frame_length`.
  - Other addresses return whatever the buffer currently holds.
- `drop_count` saturates at 16'hFFFF and never wraps.
- `frame_length` keeps its last value after release until the next good frame.

## Timing
- **Reset** (`reset_n` low, asynchronous):
  - state=RECEIVE, `wr_ptr=0`.
  - `s_axis_tready=0`, `frame_valid=0`, `frame_length=0`, `rd_data=0`, `drop_count=0`.
  - Buffer memory is not reset.
- Reset mid-frame abandons the partial frame with no drop counted. The first beat after reset is stored at address 0.
- `frame_valid` rises on the cycle after the good `tlast` handshake. `s_axis_tready` falls on that same cycle.
- `frame_release` sampled high in HOLD:
  - `frame_valid=0` and `s_axis_tready=1` on the next cycle.
  - Minimum one-cycle gap between frames.
- Read latency is 1 cycle: `rd_addr` applied in cycle N gives `rd_data` in cycle N+1.
- Gaps in `tvalid` (bubbles) are allowed anywhere and do not change state.
- Drop counter updates on the cycle after the discarding `tlast` beat.

## Test plan
- **Basic frame:** bytes 0x11,0x22,0x33,0x44 with `tlast` on 0x44 and `tuser=0`.
  - `frame_valid=1`, `frame_length=4`, `tready=0` one cycle later.
  - `rd_addr` 0..3 returns 0x11..0x44 each one cycle later.
  - Pulsing `frame_release` brings `tready=1` on the next cycle.
- **Bad frame:** 3 bytes with `tuser=1` on `tlast`.
  - `frame_valid` never rises, `drop_count=1`, `tready` stays 1.
  - A following good 2-byte frame reads back at addresses 0..1.
- **Oversize and exact fit** (`MAX_FRAME_BYTES=16`):
  - A 20-byte frame gives `drop_count=1` and no `frame_valid`.
  - A following 16-byte frame gives `frame_valid=1`, `frame_length=16`, and bytes read back intact.
- **Backpressure:** a second frame is offered while HOLD is active.
  - `tready` stays 0 and the held data is unchanged.
  - After release, the second frame (5 bytes with random `tvalid` bubbles) gives `frame_length=5` with correct data.
- **Reset mid-frame:** deassert `reset_n` after 3 beats of an 8-byte frame.
  - All outputs reach reset values immediately and `drop_count=0`.
  - The next 4-byte frame gives `frame_length=4`.
- **Saturation:** preload or drive 65536 bad frames. `drop_count` holds at 16'hFFFF.
